// File: rtl/gobou_ctrl_relu_pkg.sv
// Shared definitions for the gobou relu-stage controller and its datapath neighbours.
// RELU_LAT lives here so gobou_relu and this controller always agree on latency.
package gobou_ctrl_relu_pkg;

    localparam int LWIDTH_DEF     = 10;
    localparam int OADDRWIDTH_DEF = 12;
    localparam int RELU_LAT       = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gobou_delay_line.sv
// Parameterised shift register with async active-low reset.
// o_pre is the value that o_q will show one cycle later, for aligning side registers.
module gobou_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_pre,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    generate
        if (DEPTH == 1) begin : g_pre_in
            assign o_pre = i_d;
        end else begin : g_pre_sr
            assign o_pre = r_sr[DEPTH-2];
        end
    endgenerate

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/gobou_ctrl_relu.sv
// Sequencer for the gobou relu stage: gates relu enable, delays the bias valid to
// match relu latency and writes results into output memory, then acks the core.
//
//   state   | meaning
//   S_IDLE  | waiting for req; config latched on accept
//   S_RUN   | accepting in_valid words until out_size have arrived
//   S_DRAIN | waiting for the delayed writes to finish
//   S_DONE  | one-cycle ack, back to S_IDLE
module gobou_ctrl_relu #(
    parameter int LWIDTH     = gobou_ctrl_relu_pkg::LWIDTH_DEF,
    parameter int OADDRWIDTH = gobou_ctrl_relu_pkg::OADDRWIDTH_DEF,
    parameter int RELU_LAT   = gobou_ctrl_relu_pkg::RELU_LAT
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic                  req,
    input  logic [LWIDTH-1:0]     out_size,
    input  logic [OADDRWIDTH-1:0] out_offset,
    input  logic                  relu_on,
    input  logic                  in_valid,
    output logic                  relu_en,
    output logic                  relu_bypass,
    output logic                  mem_we,
    output logic [OADDRWIDTH-1:0] mem_addr,
    output logic                  busy,
    output logic                  ack
);

    import gobou_ctrl_relu_pkg::state_t;
    import gobou_ctrl_relu_pkg::S_IDLE;
    import gobou_ctrl_relu_pkg::S_RUN;
    import gobou_ctrl_relu_pkg::S_DRAIN;
    import gobou_ctrl_relu_pkg::S_DONE;

    localparam logic [LWIDTH-1:0] ONE_L = 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LWIDTH-1:0]     r_size;
    logic [LWIDTH-1:0]     r_in_cnt;
    logic [LWIDTH-1:0]     r_wr_cnt;
    logic [OADDRWIDTH-1:0] r_offset;
    logic [OADDRWIDTH-1:0] r_mem_addr;
    logic                  r_relu_on;
    logic                  w_start;
    logic                  w_acc_valid;
    logic                  w_last_in;
    logic                  w_pre_we;
    logic                  w_mem_we;

    assign w_start     = (r_state == S_IDLE) && req;
    assign w_acc_valid = in_valid && (r_state == S_RUN);
    assign w_last_in   = w_acc_valid && ((r_in_cnt + ONE_L) == r_size);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_nxt = (out_size == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_in) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_wr_cnt == r_size) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state   <= S_IDLE;
            r_size    <= '0;
            r_offset  <= '0;
            r_relu_on <= 1'b0;
            r_in_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_size    <= out_size;
                r_offset  <= out_offset;
                r_relu_on <= relu_on;
                r_in_cnt  <= '0;
            end else if (w_acc_valid) begin
                r_in_cnt <= r_in_cnt + ONE_L;
            end
        end
    end

    gobou_delay_line #(
        .DEPTH (RELU_LAT),
        .WIDTH (1)
    ) u_valid_dly (
        .clk   (clk),
        .xrst  (xrst),
        .i_d   (w_acc_valid),
        .o_pre (w_pre_we),
        .o_q   (w_mem_we)
    );

    // Address is loaded on the same edge that raises mem_we, so it lines up with the tap.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_wr_cnt   <= '0;
            r_mem_addr <= '0;
        end else if (w_start) begin
            r_wr_cnt <= '0;
        end else if (w_pre_we) begin
            r_mem_addr <= r_offset + OADDRWIDTH'(r_wr_cnt);
            r_wr_cnt   <= r_wr_cnt + ONE_L;
        end
    end

    assign relu_en     = w_acc_valid && r_relu_on;
    assign relu_bypass = ~(r_relu_on && (r_state != S_IDLE));
    assign mem_we      = w_mem_we;
    assign mem_addr    = r_mem_addr;
    assign busy        = (r_state != S_IDLE);
    assign ack         = (r_state == S_DONE);

endmodule

// File: tb/tb_gobou_ctrl_relu.sv
// Directed bench for gobou_ctrl_relu: two instances (relu latency 1 and 3) share stimulus;
// expected writes are queued when a valid is accepted and popped as mem_we appears.
module tb_gobou_ctrl_relu;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        req = 1'b0;
    logic        relu_on = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  out_size = '0;
    logic [11:0] out_offset = '0;

    logic        relu_en1, relu_bypass1, mem_we1, busy1, ack1;
    logic [11:0] mem_addr1;
    logic        relu_en3, relu_bypass3, mem_we3, busy3, ack3;
    logic [11:0] mem_addr3;

    typedef struct {
        int          c;
        logic [11:0] a;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    exp_t        e1, e3;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_cyc1, ack_cyc3, ack_cnt1, ack_cnt3, last_c1, last_c3, req_cyc;
    logic        ackd1 = 1'b0;
    logic        ackd3 = 1'b0;
    logic        m_active = 1'b0;
    logic        m_ron = 1'b0;
    int          m_left = 0;
    int          m_idx = 0;
    logic [11:0] m_off = '0;

    gobou_ctrl_relu #(.LWIDTH(10), .OADDRWIDTH(12), .RELU_LAT(1)) dut1 (
        .clk(clk), .xrst(xrst), .req(req), .out_size(out_size), .out_offset(out_offset),
        .relu_on(relu_on), .in_valid(in_valid), .relu_en(relu_en1), .relu_bypass(relu_bypass1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .busy(busy1), .ack(ack1)
    );

    gobou_ctrl_relu #(.LWIDTH(10), .OADDRWIDTH(12), .RELU_LAT(3)) dut3 (
        .clk(clk), .xrst(xrst), .req(req), .out_size(out_size), .out_offset(out_offset),
        .relu_on(relu_on), .in_valid(in_valid), .relu_en(relu_en3), .relu_bypass(relu_bypass3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .busy(busy3), .ack(ack3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle output monitor, called at every negedge from the stimulus thread.
    task automatic mon;
        if (!xrst) begin
            ackd1 = 1'b0;
            ackd3 = 1'b0;
            return;
        end
        if (ackd1) chk("busy1_after_ack", busy1, 0);
        if (ackd3) chk("busy3_after_ack", busy3, 0);
        ackd1 = ack1;
        ackd3 = ack3;
        if (ack1) begin
            ack_cnt1++;
            ack_cyc1 = cyc;
            chk("busy1_at_ack", busy1, 1);
        end
        if (ack3) begin
            ack_cnt3++;
            ack_cyc3 = cyc;
            chk("busy3_at_ack", busy3, 1);
        end
        if (mem_we1) begin
            chk("write1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("write1_addr", mem_addr1, e1.a);
                chk("write1_cycle", cyc, e1.c);
            end
        end
        if (mem_we3) begin
            chk("write3_expected", q3.size() != 0, 1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk("write3_addr", mem_addr3, e3.a);
                chk("write3_cycle", cyc, e3.c);
            end
        end
    endtask

    task automatic step;
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [9:0] size, input logic [11:0] off, input logic ron);
        out_size   = size;
        out_offset = off;
        relu_on    = ron;
        req        = 1'b1;
        req_cyc    = cyc;
        m_active   = 1'b1;
        m_ron      = ron;
        m_left     = size;
        m_idx      = 0;
        m_off      = off;
        ack_cnt1   = 0;
        ack_cnt3   = 0;
        ack_cyc1   = -1;
        ack_cyc3   = -1;
        last_c1    = req_cyc;
        last_c3    = req_cyc;
        step();
        req        = 1'b0;
        out_size   = 10'($urandom);
        out_offset = 12'($urandom);
        relu_on    = ~ron;
    endtask

    task automatic valid_cycle(input logic v);
        logic        acc;
        logic [11:0] a;
        in_valid = v;
        acc = v && m_active && (m_left > 0);
        if (acc) begin
            a = m_off + 12'(m_idx);
            q1.push_back('{cyc + 1, a});
            q3.push_back('{cyc + 3, a});
            last_c1 = cyc + 1;
            last_c3 = cyc + 3;
            m_idx++;
            m_left--;
        end
        @(negedge clk);
        chk("relu_en1", relu_en1, acc && m_ron);
        chk("relu_en3", relu_en3, acc && m_ron);
        chk("relu_bypass1", relu_bypass1, m_active ? !m_ron : 1'b1);
        chk("busy1", busy1, m_active);
        mon();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic end_job;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && q3.size() == 0 && ack_cnt1 > 0 && ack_cnt3 > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("job_done_in_time", ok, 1);
        chk("ack1_cycle", ack_cyc1, last_c1 + 1);
        chk("ack3_cycle", ack_cyc3, last_c3 + 1);
        step();
        step();
        m_active = 1'b0;
        chk("ack1_count", ack_cnt1, 1);
        chk("ack3_count", ack_cnt3, 1);
        chk("busy1_idle", busy1, 0);
        chk("busy3_idle", busy3, 0);
        chk("relu_bypass1_idle", relu_bypass1, 1);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_relu_en", relu_en1, 0);
        chk("rst_relu_bypass", relu_bypass1, 1);
        chk("rst_mem_we", mem_we1, 0);
        chk("rst_mem_addr", mem_addr1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ack", ack1, 0);
        chk("rst_mem_we3", mem_we3, 0);
        xrst = 1'b1;
        step();

        // basic job: valids on cycles 3..6 after req
        start_job(10'd4, 12'h100, 1'b1);
        valid_cycle(0); valid_cycle(0);
        repeat (4) valid_cycle(1);
        end_job();

        // gapped input: valids on cycles 3, 5, 9
        start_job(10'd3, 12'h2A0, 1'b1);
        valid_cycle(0); valid_cycle(0); valid_cycle(1); valid_cycle(0); valid_cycle(1);
        valid_cycle(0); valid_cycle(0); valid_cycle(0); valid_cycle(1);
        end_job();

        // bypass job
        start_job(10'd4, 12'h100, 1'b0);
        valid_cycle(0); valid_cycle(0);
        repeat (4) valid_cycle(1);
        end_job();

        // in_valid while idle must not write
        valid_cycle(1); valid_cycle(0); valid_cycle(1);
        repeat (4) step();

        // zero-size job
        start_job(10'd0, 12'h123, 1'b1);
        end_job();

        // address wrap
        start_job(10'd3, 12'hFFE, 1'b1);
        repeat (3) valid_cycle(1);
        end_job();

        // second req during job is ignored; fifth valid is an overrun
        start_job(10'd4, 12'h300, 1'b1);
        valid_cycle(0); valid_cycle(1);
        req = 1'b1; out_size = 10'd7; out_offset = 12'h7A0; relu_on = 1'b0;
        valid_cycle(1);
        req = 1'b0;
        valid_cycle(1); valid_cycle(1); valid_cycle(1);
        end_job();

        // mid-job reset after two words
        start_job(10'd4, 12'h200, 1'b1);
        valid_cycle(0); valid_cycle(1); valid_cycle(1); valid_cycle(0);
        chk("q1_drained_before_reset", q1.size(), 0);
        xrst = 1'b0;
        in_valid = 1'b1;
        q3.delete();
        m_active = 1'b0;
        #1;
        chk("mrst_relu_en1", relu_en1, 0);
        chk("mrst_relu_bypass1", relu_bypass1, 1);
        chk("mrst_mem_we1", mem_we1, 0);
        chk("mrst_mem_addr1", mem_addr1, 0);
        chk("mrst_busy1", busy1, 0);
        chk("mrst_ack1", ack1, 0);
        chk("mrst_mem_we3", mem_we3, 0);
        chk("mrst_mem_addr3", mem_addr3, 0);
        chk("mrst_busy3", busy3, 0);
        chk("mrst_relu_bypass3", relu_bypass3, 1);
        step(); step();
        in_valid = 1'b0;
        xrst = 1'b1;
        step();

        // fresh job after reset
        start_job(10'd2, 12'h040, 1'b0);
        valid_cycle(1); valid_cycle(1);
        end_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
